// File: rtl/quic_long_hdr_tx.sv
// QUIC v1 long-header serializer (Initial / 0-RTT / Handshake), one byte per beat, MSB first.
// Latency: first header byte valid the cycle after an accepted start; one byte per cycle with dout_ready=1.
// Backpressure: while dout_valid && !dout_ready the byte, dout_last and state hold; start ignored while busy.
module quic_long_hdr_tx #(
  parameter int          MAX_CID = 20,
  parameter logic [31:0] VERSION = 32'h0000_0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           pkt_type,
  input  logic [1:0]           pn_len,
  input  logic [31:0]          pn,
  input  logic [4:0]           dcid_len,
  input  logic [8*MAX_CID-1:0] dcid,
  input  logic [4:0]           scid_len,
  input  logic [8*MAX_CID-1:0] scid,
  input  logic [15:0]          payload_len,
  output logic [7:0]           dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic                 busy,
  output logic                 err
);

  localparam logic [4:0] MAX_CID_L = 5'(MAX_CID);

  typedef enum logic [3:0] {
    S_IDLE, S_FIRST, S_VER, S_DCIL, S_DCID, S_SCIL, S_SCID, S_TOKL, S_LEN, S_PN
  } state_t;

  state_t      state;
  logic [4:0]  cnt;

  // Fields captured on an accepted start
  logic [1:0]  type_q;
  logic [1:0]  pn_len_q;
  logic [31:0] pn_q;
  logic [4:0]  dcid_len_q;
  logic [4:0]  scid_len_q;
  logic [7:0]  dcid_q [MAX_CID];
  logic [7:0]  scid_q [MAX_CID];
  logic [16:0] len_q;

  state_t      nxt_state;
  state_t      after_scid;
  logic [4:0]  nxt_cnt;
  logic [7:0]  nxt_byte;
  logic        nxt_last;
  logic [2:0]  len_bytes;
  logic [29:0] len_ext;
  logic [1:0]  ver_sel;
  logic [1:0]  pn_sel;
  logic        bad_start;

  assign bad_start = (pkt_type == 2'b11) || (dcid_len > MAX_CID_L) || (scid_len > MAX_CID_L);
  assign len_ext   = 30'(len_q);
  assign after_scid = (type_q == 2'b00) ? S_TOKL : S_LEN;

  // Size of the minimal varint encoding of the Length field
  always_comb begin
    len_bytes = 3'd4;
    if (len_q < 17'd64)         len_bytes = 3'd1;
    else if (len_q < 17'd16384) len_bytes = 3'd2;
  end

  // Where the serializer goes after the current byte is handshaken
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 5'd1;
    case (state)
      S_FIRST: begin nxt_state = S_VER; nxt_cnt = 5'd0; end
      S_VER:   if (cnt[1:0] == 2'd3) begin nxt_state = S_DCIL; nxt_cnt = 5'd0; end
      S_DCIL:  begin
        nxt_cnt   = 5'd0;
        nxt_state = (dcid_len_q == 5'd0) ? S_SCIL : S_DCID;
      end
      S_DCID:  if ((cnt + 5'd1) == dcid_len_q) begin nxt_state = S_SCIL; nxt_cnt = 5'd0; end
      S_SCIL:  begin
        nxt_cnt   = 5'd0;
        nxt_state = (scid_len_q == 5'd0) ? after_scid : S_SCID;
      end
      S_SCID:  if ((cnt + 5'd1) == scid_len_q) begin nxt_state = after_scid; nxt_cnt = 5'd0; end
      S_TOKL:  begin nxt_state = S_LEN; nxt_cnt = 5'd0; end
      S_LEN:   if ((cnt[2:0] + 3'd1) == len_bytes) begin nxt_state = S_PN; nxt_cnt = 5'd0; end
      S_PN:    if (cnt[1:0] == pn_len_q) begin nxt_state = S_IDLE; nxt_cnt = 5'd0; end
      default: begin nxt_state = S_IDLE; nxt_cnt = 5'd0; end
    endcase
  end

  // Byte to present in the next state/position, taken from the captured fields
  always_comb begin
    nxt_byte = 8'h00;
    nxt_last = 1'b0;
    ver_sel  = 2'd3 - nxt_cnt[1:0];
    pn_sel   = pn_len_q - nxt_cnt[1:0];
    case (nxt_state)
      S_VER:  nxt_byte = VERSION[{ver_sel, 3'b000} +: 8];
      S_DCIL: nxt_byte = {3'b000, dcid_len_q};
      S_DCID: nxt_byte = dcid_q[nxt_cnt];
      S_SCIL: nxt_byte = {3'b000, scid_len_q};
      S_SCID: nxt_byte = scid_q[nxt_cnt];
      S_TOKL: nxt_byte = 8'h00;
      S_LEN: begin
        if (len_bytes == 3'd1) begin
          nxt_byte = {2'b00, len_ext[5:0]};
        end else if (len_bytes == 3'd2) begin
          nxt_byte = (nxt_cnt[1:0] == 2'd0) ? {2'b01, len_ext[13:8]} : len_ext[7:0];
        end else begin
          case (nxt_cnt[1:0])
            2'd0:    nxt_byte = {2'b10, len_ext[29:24]};
            2'd1:    nxt_byte = len_ext[23:16];
            2'd2:    nxt_byte = len_ext[15:8];
            default: nxt_byte = len_ext[7:0];
          endcase
        end
      end
      S_PN: begin
        nxt_byte = pn_q[{pn_sel, 3'b000} +: 8];
        nxt_last = (nxt_cnt[1:0] == pn_len_q);
      end
      default: nxt_byte = 8'h00;
    endcase
  end

  // Header FSM: capture on start, advance one byte per handshake, registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 5'd0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == S_IDLE) begin
        if (start) begin
          if (bad_start) begin
            err <= 1'b1;
          end else begin
            type_q     <= pkt_type;
            pn_len_q   <= pn_len;
            pn_q       <= pn;
            dcid_len_q <= dcid_len;
            scid_len_q <= scid_len;
            for (int i = 0; i < MAX_CID; i++) begin
              dcid_q[i] <= dcid[8*(MAX_CID-1-i) +: 8];
              scid_q[i] <= scid[8*(MAX_CID-1-i) +: 8];
            end
            len_q      <= {1'b0, payload_len} + {15'd0, pn_len} + 17'd1;
            state      <= S_FIRST;
            cnt        <= 5'd0;
            dout       <= {2'b11, pkt_type, 2'b00, pn_len};
            dout_valid <= 1'b1;
            dout_last  <= 1'b0;
            busy       <= 1'b1;
          end
        end
      end else if (dout_valid && dout_ready) begin
        state <= nxt_state;
        cnt   <= nxt_cnt;
        if (nxt_state == S_IDLE) begin
          dout       <= 8'h00;
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
          busy       <= 1'b0;
        end else begin
          dout      <= nxt_byte;
          dout_last <= nxt_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_quic_long_hdr_tx.sv
// Bench for quic_long_hdr_tx: directed spec vectors plus randomized headers against a byte-list model.
// Checks byte order, dout_last, stall stability, busy/valid timing, error pulses and mid-header reset.
module tb_quic_long_hdr_tx;

  typedef logic [7:0] bq_t[$];

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   pkt_type;
  logic [1:0]   pn_len;
  logic [31:0]  pn;
  logic [4:0]   dcid_len;
  logic [159:0] dcid;
  logic [4:0]   scid_len;
  logic [159:0] scid;
  logic [15:0]  payload_len;
  logic [7:0]   dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic         busy;
  logic         err;

  int checks   = 0;
  int failures = 0;

  quic_long_hdr_tx #(.MAX_CID(20), .VERSION(32'h0000_0001)) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_type(pkt_type), .pn_len(pn_len), .pn(pn),
    .dcid_len(dcid_len), .dcid(dcid), .scid_len(scid_len), .scid(scid),
    .payload_len(payload_len), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected header as a list of bytes, built straight from the field rules
  function automatic bq_t model(input logic [1:0] t, input logic [1:0] pl, input logic [31:0] pnv,
                                input logic [4:0] dl, input logic [159:0] dc,
                                input logic [4:0] sl, input logic [159:0] sc, input logic [15:0] plen);
    bq_t q;
    int  len;
    q.push_back(8'(192 + 16 * t + pl));
    for (int i = 0; i < 4; i++) q.push_back(8'(32'h0000_0001 >> (24 - 8 * i)));
    q.push_back(8'(dl));
    for (int i = 0; i < dl; i++) q.push_back(dc[159 - 8 * i -: 8]);
    q.push_back(8'(sl));
    for (int i = 0; i < sl; i++) q.push_back(sc[159 - 8 * i -: 8]);
    if (t == 2'b00) q.push_back(8'h00);
    len = int'(plen) + int'(pl) + 1;
    if (len < 64) begin
      q.push_back(8'(len));
    end else if (len < 16384) begin
      q.push_back(8'(64 + len / 256));
      q.push_back(8'(len % 256));
    end else begin
      q.push_back(8'(128 + (len >> 24)));
      q.push_back(8'(len >> 16));
      q.push_back(8'(len >> 8));
      q.push_back(8'(len));
    end
    for (int i = int'(pl); i >= 0; i--) q.push_back(8'(pnv >> (8 * i)));
    return q;
  endfunction

  task automatic set_fields(input logic [1:0] t, input logic [1:0] pl, input logic [31:0] pnv,
                            input logic [4:0] dl, input logic [159:0] dc,
                            input logic [4:0] sl, input logic [159:0] sc, input logic [15:0] plen);
    pkt_type = t; pn_len = pl; pn = pnv; dcid_len = dl; dcid = dc;
    scid_len = sl; scid = sc; payload_len = plen;
  endtask

  // Start a header and consume it; rnd toggles dout_ready, poke issues a start mid-header,
  // abort_at>0 pulses rst right after that many bytes have been accepted.
  task automatic run_hdr(input string name, input bq_t exp, input bit rnd, input bit poke, input int abort_at);
    int         n = 0;
    int         cyc = 0;
    bit         stalled = 0;
    logic [7:0] prev_dout = 8'h00;
    logic       prev_last = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, ":busy_after_start"}, busy, 1);
    check({name, ":valid_after_start"}, dout_valid, 1);
    while (n < exp.size() && cyc < 2000) begin
      if (stalled) begin
        check({name, ":stall_dout"}, dout, prev_dout);
        check({name, ":stall_last"}, dout_last, prev_last);
      end
      check({name, ":valid_held"}, dout_valid, 1);
      if (poke && cyc == 4) check({name, ":no_err_busy_start"}, err, 0);
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (poke && cyc == 3);
      if (poke && cyc == 3) begin
        pkt_type = 2'b11;
        dcid_len = 5'd21;
      end
      if (dout_ready) begin
        check($sformatf("%s:byte%0d", name, n), dout, exp[n]);
        check($sformatf("%s:last%0d", name, n), dout_last, (n == exp.size() - 1));
        n++;
        stalled = 0;
      end else begin
        stalled = 1;
        prev_dout = dout;
        prev_last = dout_last;
      end
      @(posedge clk); #1;
      cyc++;
      if (abort_at > 0 && n == abort_at) begin
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check({name, ":abort_dout"}, dout, 0);
        check({name, ":abort_valid"}, dout_valid, 0);
        check({name, ":abort_last"}, dout_last, 0);
        check({name, ":abort_busy"}, busy, 0);
        check({name, ":abort_err"}, err, 0);
        return;
      end
    end
    start = 1'b0;
    check({name, ":bytes_accepted"}, n, exp.size());
    check({name, ":valid_after_end"}, dout_valid, 0);
    check({name, ":busy_after_end"}, busy, 0);
    check({name, ":last_after_end"}, dout_last, 0);
    if (!rnd) check({name, ":cycles"}, cyc, exp.size());
  endtask

  task automatic err_case(input string name);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, ":err_pulse"}, err, 1);
    check({name, ":no_valid"}, dout_valid, 0);
    check({name, ":no_busy"}, busy, 0);
    @(posedge clk); #1;
    check({name, ":err_cleared"}, err, 0);
    check({name, ":still_no_valid"}, dout_valid, 0);
  endtask

  logic [159:0] dc1;
  logic [159:0] sc2;
  bq_t          e1;
  bq_t          e2;
  bq_t          e3;
  logic [15:0]  plen_tab [8];

  initial begin
    rst = 1'b1; start = 1'b0; dout_ready = 1'b0;
    set_fields(2'b00, 2'd0, 32'd0, 5'd0, 160'd0, 5'd0, 160'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset:dout", dout, 0);
    check("reset:valid", dout_valid, 0);
    check("reset:last", dout_last, 0);
    check("reset:busy", busy, 0);
    check("reset:err", err, 0);
    @(posedge clk); #1;

    // Initial header, full-rate
    dc1 = {64'h8394_C8F0_3E51_5708, 96'd0};
    e1 = '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h83, 8'h94, 8'hC8, 8'hF0, 8'h3E,
           8'h51, 8'h57, 8'h08, 8'h00, 8'h00, 8'h44, 8'h8E, 8'h00, 8'h00, 8'h00, 8'h02};
    set_fields(2'b00, 2'd3, 32'd2, 5'd8, dc1, 5'd0, 160'd0, 16'd1162);
    run_hdr("initial", e1, 0, 0, 0);

    // Handshake header, started in the cycle right after the previous one ended
    sc2 = {32'hAABB_CCDD, 128'd0};
    e2 = '{8'hE0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h15, 8'h7F};
    set_fields(2'b10, 2'd0, 32'h7F, 5'd0, 160'd0, 5'd4, sc2, 16'd20);
    run_hdr("handshake", e2, 0, 0, 0);

    // 0-RTT header with 4-byte Length
    e3 = '{8'hD3, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h11, 8'h22, 8'h01, 8'h33,
           8'h80, 8'h01, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
    set_fields(2'b01, 2'd3, 32'h0102_0304, 5'd2, {16'h1122, 144'd0}, 5'd1, {8'h33, 152'd0}, 16'd65535);
    run_hdr("zero_rtt", e3, 0, 0, 0);

    // Backpressure on the Initial header, with a start poked in mid-header
    set_fields(2'b00, 2'd3, 32'd2, 5'd8, dc1, 5'd0, 160'd0, 16'd1162);
    run_hdr("initial_bp", e1, 1, 1, 0);
    @(posedge clk); #1;

    // Rejected starts
    set_fields(2'b11, 2'd0, 32'd1, 5'd1, dc1, 5'd0, 160'd0, 16'd5);
    err_case("retry");
    set_fields(2'b00, 2'd0, 32'd1, 5'd21, dc1, 5'd0, 160'd0, 16'd5);
    err_case("dcid21");
    set_fields(2'b10, 2'd0, 32'd1, 5'd0, dc1, 5'd21, 160'd0, 16'd5);
    err_case("scid21");

    // Reset after byte 5, then a full clean run
    set_fields(2'b00, 2'd3, 32'd2, 5'd8, dc1, 5'd0, 160'd0, 16'd1162);
    run_hdr("abort", e1, 0, 0, 5);
    @(posedge clk); #1;
    set_fields(2'b00, 2'd3, 32'd2, 5'd8, dc1, 5'd0, 160'd0, 16'd1162);
    run_hdr("after_abort", e1, 0, 0, 0);

    // Randomized headers around the varint size boundaries
    plen_tab = '{16'd0, 16'd59, 16'd60, 16'd62, 16'd16379, 16'd16380, 16'd16383, 16'd65535};
    for (int k = 0; k < 24; k++) begin
      logic [1:0]  t;
      logic [1:0]  pl;
      logic [15:0] plen;
      t    = 2'($urandom_range(0, 2));
      pl   = 2'($urandom_range(0, 3));
      plen = (k % 3 == 0) ? 16'($urandom) : plen_tab[$urandom_range(0, 7)];
      set_fields(t, pl, $urandom, 5'($urandom_range(0, 20)),
                 {$urandom, $urandom, $urandom, $urandom, $urandom},
                 5'($urandom_range(0, 20)),
                 {$urandom, $urandom, $urandom, $urandom, $urandom}, plen);
      run_hdr($sformatf("rand%0d", k),
              model(pkt_type, pn_len, pn, dcid_len, dcid, scid_len, scid, payload_len),
              (k % 2 == 1), (k % 5 == 2), 0);
      if (k % 4 == 3) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
